// File: rtl/at86rf215_iq_unpacker.sv
// AT86RF215 raw I/Q word unpacker: sync check, 13->16 bit sign extension and
// packet framing onto an AXI4-Stream master behind a 2-entry skid buffer.
module at86rf215_iq_unpacker #(
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int PKT_LEN_WIDTH          = 16
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic                              enable,
  input  logic [PKT_LEN_WIDTH-1:0]          packet_len,
  input  logic                              s00_axis_tvalid,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
  input  logic                              s00_axis_tlast,
  output logic                              s00_axis_tready,
  output logic                              m00_axis_tvalid,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata,
  output logic                              m00_axis_tlast,
  input  logic                              m00_axis_tready,
  output logic                              sync_err,
  output logic [15:0]                       sync_err_count
);

  function automatic logic sync_ok(input logic [C_S00_AXIS_TDATA_WIDTH-1:0] w);
    return (w[31:30] == 2'b10) && (w[15:14] == 2'b01);
  endfunction

  function automatic logic [C_M00_AXIS_TDATA_WIDTH-1:0] unpack(input logic [C_S00_AXIS_TDATA_WIDTH-1:0] w);
    return {{3{w[13]}}, w[13:1], {3{w[29]}}, w[29:17]};
  endfunction

  logic [1:0]                        fill_r;
  logic [1:0]                        fill_next_s;
  logic                              ready_r;
  logic                              head_valid_r;
  logic [C_M00_AXIS_TDATA_WIDTH-1:0] head_data_r;
  logic                              head_last_r;
  logic [C_M00_AXIS_TDATA_WIDTH-1:0] skid_data_r;
  logic                              skid_last_r;
  logic [PKT_LEN_WIDTH-1:0]          cnt_r;
  logic [PKT_LEN_WIDTH-1:0]          len_r;
  logic                              err_r;
  logic [15:0]                       err_cnt_r;

  logic                              accept_s;
  logic                              good_s;
  logic                              push_s;
  logic                              bad_s;
  logic                              pop_s;
  logic [PKT_LEN_WIDTH-1:0]          lim_s;
  logic                              last_s;
  logic [C_M00_AXIS_TDATA_WIDTH-1:0] new_data_s;

  // Word classification, packet limit selection and FIFO occupancy update
  always_comb begin
    accept_s    = s00_axis_tvalid & ready_r;
    good_s      = sync_ok(s00_axis_tdata);
    push_s      = accept_s & enable & good_s;
    bad_s       = accept_s & enable & ~good_s;
    pop_s       = head_valid_r & m00_axis_tready;
    new_data_s  = unpack(s00_axis_tdata);
    if (cnt_r == {PKT_LEN_WIDTH{1'b0}}) begin
      lim_s = (packet_len == {PKT_LEN_WIDTH{1'b0}}) ? {{(PKT_LEN_WIDTH-1){1'b0}}, 1'b1} : packet_len;
    end else begin
      lim_s = len_r;
    end
    last_s      = s00_axis_tlast | (cnt_r == (lim_s - {{(PKT_LEN_WIDTH-1){1'b0}}, 1'b1}));
    fill_next_s = fill_r;
    case ({push_s, pop_s})
      2'b10:   fill_next_s = fill_r + 2'd1;
      2'b01:   fill_next_s = fill_r - 2'd1;
      default: fill_next_s = fill_r;
    endcase
  end

  // Skid buffer: head register drives m00 directly, skid holds the second entry
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      fill_r       <= 2'd0;
      ready_r      <= 1'b0;
      head_valid_r <= 1'b0;
      head_data_r  <= '0;
      head_last_r  <= 1'b0;
      skid_data_r  <= '0;
      skid_last_r  <= 1'b0;
    end else begin
      fill_r  <= fill_next_s;
      ready_r <= (fill_next_s != 2'd2);
      case (fill_r)
        2'd0: begin
          if (push_s) begin
            head_valid_r <= 1'b1;
            head_data_r  <= new_data_s;
            head_last_r  <= last_s;
          end
        end
        2'd1: begin
          if (push_s && pop_s) begin
            head_data_r <= new_data_s;
            head_last_r <= last_s;
          end else if (push_s) begin
            skid_data_r <= new_data_s;
            skid_last_r <= last_s;
          end else if (pop_s) begin
            head_valid_r <= 1'b0;
          end
        end
        2'd2: begin
          if (pop_s) begin
            head_data_r <= skid_data_r;
            head_last_r <= skid_last_r;
          end
        end
        default: begin
          head_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Packet framing; the length is latched on the first sample of each packet
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_r <= '0;
      len_r <= '0;
    end else if (!enable || bad_s) begin
      cnt_r <= '0;
    end else if (push_s) begin
      if (cnt_r == {PKT_LEN_WIDTH{1'b0}}) begin
        len_r <= lim_s;
      end
      cnt_r <= last_s ? {PKT_LEN_WIDTH{1'b0}} : cnt_r + {{(PKT_LEN_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // Sync error pulse and saturating drop counter
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      err_r     <= 1'b0;
      err_cnt_r <= 16'h0000;
    end else begin
      err_r <= bad_s;
      if (bad_s && (err_cnt_r != 16'hFFFF)) begin
        err_cnt_r <= err_cnt_r + 16'h0001;
      end
    end
  end

  assign s00_axis_tready = ready_r;
  assign m00_axis_tvalid = head_valid_r;
  assign m00_axis_tdata  = head_data_r;
  assign m00_axis_tlast  = head_last_r;
  assign sync_err        = err_r;
  assign sync_err_count  = err_cnt_r;

endmodule

// File: tb/tb_at86rf215_iq_unpacker.sv
// Scoreboard bench for at86rf215_iq_unpacker: the driver pushes hand-computed
// expected samples, a negedge monitor pops and compares on every m00 handshake.
module tb_at86rf215_iq_unpacker;

  localparam int K_OK  = 0;
  localparam int K_BAD = 1;
  localparam int K_DIS = 2;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [15:0] packet_len;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_last;
  logic        s_ready;
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_last;
  logic        m_ready;
  logic        sync_err;
  logic [15:0] sync_err_count;

  logic [32:0] sb[$];
  int          vec = 0;
  int          errs = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          acc_n = 0;
  int          last_pop_cyc = 0;
  logic        pend_err = 1'b0;
  logic        hold_v = 1'b0;
  logic [32:0] hold_d = 33'd0;
  logic [15:0] err_model = 16'h0000;
  logic [31:0] bad_words[4];

  at86rf215_iq_unpacker dut (
    .aclk            (clk),
    .aresetn         (rst_n),
    .enable          (enable),
    .packet_len      (packet_len),
    .s00_axis_tvalid (s_valid),
    .s00_axis_tdata  (s_data),
    .s00_axis_tlast  (s_last),
    .s00_axis_tready (s_ready),
    .m00_axis_tvalid (m_valid),
    .m00_axis_tdata  (m_data),
    .m00_axis_tlast  (m_last),
    .m00_axis_tready (m_ready),
    .sync_err        (sync_err),
    .sync_err_count  (sync_err_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: sync_err pulse, hold stability and in-order sample checking
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v   = 1'b0;
      pend_err = 1'b0;
    end else begin
      chk("sync_err", {32'd0, sync_err}, {32'd0, pend_err});
      pend_err = 1'b0;
      if (hold_v) chk("hold", {m_valid, m_last, m_data}, {1'b1, hold_d});
      hold_v = m_valid & ~m_ready;
      hold_d = {m_last, m_data};
      if (m_valid && m_ready) begin
        last_pop_cyc = cyc;
        if (sb.size() == 0) begin
          vec++;
          errs++;
          $display("FAIL unexpected: got %h expected nothing", {m_last, m_data});
        end else begin
          chk("sample", {m_last, m_data}, sb.pop_front());
        end
      end
    end
  end

  function automatic logic [31:0] mk(input logic [12:0] i, input logic [12:0] q);
    return {2'b10, i, 1'b0, 2'b01, q, 1'b0};
  endfunction

  task automatic send(input logic [31:0] w, input logic l, input int kind,
                      input logic [31:0] ed, input logic el);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = w;
    s_last  = l;
    for (int b = 0; !s_ready; b++) begin
      if (b >= 200) begin
        vec++;
        errs++;
        $display("FAIL tready_timeout: got 0 expected 1 within 200 cycles");
        s_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    acc_cyc = cyc;
    @(posedge clk);
    acc_n++;
    if (kind == K_OK) sb.push_back({el, ed});
    if (kind == K_BAD) begin
      pend_err = 1'b1;
      if (err_model != 16'hFFFF) err_model = err_model + 16'h0001;
    end
    #1 s_valid = 1'b0;
  endtask

  // Small positive I/Q values: sign extension leaves them zero-extended
  task automatic sv(input int n, input logic el);
    send(mk(13'(n), 13'(n + 256)), 1'b0, K_OK, {16'(n + 256), 16'(n)}, el);
  endtask

  task automatic set_mready(input logic v);
    @(posedge clk);
    #1 m_ready = v;
  endtask

  task automatic drain();
    for (int b = 0; b < 200 && sb.size() != 0; b++) @(negedge clk);
    chk("drain", 33'(sb.size()), 33'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int base;
    int t1;
    bad_words[0] = 32'h0000_0000;
    bad_words[1] = 32'hC000_4002;
    bad_words[2] = 32'h8002_C002;
    bad_words[3] = 32'h4000_8000;
    rst_n = 1'b0; enable = 1'b1; packet_len = 16'd4;
    s_valid = 1'b0; s_data = 32'd0; s_last = 1'b0; m_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {m_valid, m_last, s_ready, sync_err, m_data}, 33'd0);
    chk("rst_errcnt", {17'd0, sync_err_count}, 33'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;

    // Basic packet of 4 at full rate; word 4 carries Q_SYNC=01
    send(32'h8002_7FFE, 1'b0, K_OK, 32'hFFFF_0001, 1'b0);
    t1 = acc_cyc;
    send(32'h8004_4000, 1'b0, K_OK, 32'h0000_0002, 1'b0);
    send(32'h9FFE_6000, 1'b0, K_OK, 32'hF000_0FFF, 1'b0);
    send(32'hA000_4002, 1'b0, K_OK, 32'h0001_F000, 1'b1);
    drain();
    chk("rate", 33'(last_pop_cyc - t1), 33'd4);

    // Bad word mid-packet restarts framing; ctrl bits ignored
    send(mk(13'd5, 13'h1FFE), 1'b0, K_OK, 32'hFFFE_0005, 1'b0);
    send(32'h8003_4001, 1'b0, K_OK, 32'h0000_0001, 1'b0);
    send(32'h0000_0000, 1'b0, K_BAD, 32'd0, 1'b0);
    for (int n = 10; n < 14; n++) sv(n, n == 13);
    drain();
    chk("errcnt_1", {17'd0, sync_err_count}, 33'd1);

    // Downstream stall of 10 cycles under continuous input
    base = acc_n;
    set_mready(1'b0);
    fork
      for (int n = 20; n < 28; n++) sv(n, (n == 23) || (n == 27));
      begin
        repeat (10) @(posedge clk);
        #1;
        chk("stall_accepts", 33'(acc_n - base), 33'd2);
        chk("stall_ready", {32'd0, s_ready}, 33'd0);
        m_ready = 1'b1;
      end
    join
    drain();

    // Upstream tlast closes a packet early; mid-packet length change deferred
    packet_len = 16'd8;
    sv(30, 1'b0);
    sv(31, 1'b0);
    send(mk(13'd32, 13'd288), 1'b1, K_OK, {16'd288, 16'd32}, 1'b1);
    sv(40, 1'b0);
    packet_len = 16'd2;
    for (int n = 41; n < 48; n++) sv(n, n == 47);
    drain();

    // enable=0 discards without errors; re-enable starts a fresh packet
    sv(50, 1'b0);
    enable = 1'b0;
    send(mk(13'd51, 13'd7), 1'b0, K_DIS, 32'd0, 1'b0);
    send(32'h0000_0000, 1'b1, K_DIS, 32'd0, 1'b0);
    send(mk(13'd52, 13'd7), 1'b1, K_DIS, 32'd0, 1'b0);
    enable = 1'b1;
    sv(53, 1'b0);
    sv(54, 1'b1);
    drain();
    chk("errcnt_dis", {17'd0, sync_err_count}, 33'd1);

    // packet_len 0 and 1: tlast on every sample; then saturate the error counter
    packet_len = 16'd0;
    for (int n = 60; n < 63; n++) sv(n, 1'b1);
    packet_len = 16'd1;
    for (int n = 63; n < 66; n++) sv(n, 1'b1);
    drain();
    for (int k = 0; k < 70000; k++) send(bad_words[k % 4], k[0], K_BAD, 32'd0, 1'b0);
    repeat (2) @(negedge clk);
    chk("errcnt_model", {17'd0, sync_err_count}, {17'd0, err_model});
    chk("errcnt_sat", {17'd0, sync_err_count}, {17'd0, 16'hFFFF});

    // Asynchronous reset with two samples buffered
    packet_len = 16'd4;
    set_mready(1'b0);
    sv(70, 1'b0);
    sv(71, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_outputs", {m_valid, m_last, s_ready, sync_err, m_data}, 33'd0);
    chk("arst_errcnt", {17'd0, sync_err_count}, 33'd0);
    sb.delete();
    err_model = 16'h0000;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    for (int n = 72; n < 76; n++) sv(n, n == 75);
    drain();
    chk("errcnt_after_rst", {17'd0, sync_err_count}, 33'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
